// File: rtl/time_ascii_reporter_pkg.sv
// Shared definitions for the time ASCII reporter.
// Contents: ASCII constants used to build the report line, the FSM state
// encoding, and the field positions of the 24-bit packed time bus
// {hour[23:19], min[18:13], sec[12:7], csec[6:0]}. The watch/stopwatch
// datapath uses the same field positions.
package time_ascii_reporter_pkg;

    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int TIME_W   = 24;
    localparam int HOUR_MSB = 23;
    localparam int HOUR_LSB = 19;
    localparam int MIN_MSB  = 18;
    localparam int MIN_LSB  = 13;
    localparam int SEC_MSB  = 12;
    localparam int SEC_LSB  = 7;
    localparam int CSEC_MSB = 6;
    localparam int CSEC_LSB = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/time_ascii_reporter_if.sv
// Request / transmitter bundle of the time ASCII reporter.
// Signals:
//   i_report   request pulse for one report line
//   i_mode     0 = watch ('W'), 1 = stopwatch ('S')
//   i_time     packed binary time
//   i_tx_busy  UART transmitter busy (high for the whole byte frame)
//   o_tx_data  ASCII byte for the transmitter
//   o_tx_start single-cycle transmit strobe
//   o_busy     reporter busy with a line
// Modports: slave = reporter side, master = requester/transmitter side.
interface time_ascii_reporter_if;
    import time_ascii_reporter_pkg::*;

    logic              i_report;
    logic              i_mode;
    logic [TIME_W-1:0] i_time;
    logic              i_tx_busy;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              o_busy;

    modport slave (
        input  i_report, i_mode, i_time, i_tx_busy,
        output o_tx_data, o_tx_start, o_busy
    );

    modport master (
        output i_report, i_mode, i_time, i_tx_busy,
        input  o_tx_data, o_tx_start, o_busy
    );

endinterface

// File: rtl/bin2ascii_2digit.sv
// Converts a 7-bit binary value to two decimal ASCII digits.
// Values above 99 saturate to "99".
// Ports:
//   bin   binary input 0..127
//   tens  ASCII tens digit
//   ones  ASCII ones digit
module bin2ascii_2digit
    import time_ascii_reporter_pkg::*;
(
    input  logic [6:0] bin,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] sat;

    always_comb begin
        sat  = (bin > 7'd99) ? 7'd99 : bin;
        tens = ASCII_ZERO + 8'(sat / 7'd10);
        ones = ASCII_ZERO + 8'(sat % 7'd10);
    end

endmodule

// File: rtl/time_ascii_reporter.sv
// Sends one ASCII line "M HH:MM:SS.CC<EOL>" to a byte UART per request.
// The request snapshot (mode + time) is taken in the accepting IDLE cycle;
// digits are converted from that snapshot and registered in LOAD.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  request / transmitter bundle (slave side)
// Parameter P_EOL_CRLF: 1 = line ends CR LF (15 bytes), 0 = LF only (14).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for i_report; byte index held at 0
// LOAD      | snapshot digits registered
// SEND      | present byte; strobe o_tx_start as soon as tx is not busy
// WAIT_ACK  | wait for the transmitter to raise busy
// WAIT_DONE | wait for busy to fall, then next byte or back to IDLE
module time_ascii_reporter
    import time_ascii_reporter_pkg::*;
#(
    parameter int P_EOL_CRLF = 1
) (
    input logic                  clk,
    input logic                  rst,
    time_ascii_reporter_if.slave bus
);

    localparam logic [3:0] LAST_IDX = (P_EOL_CRLF != 0) ? 4'd14 : 4'd13;

    state_t            state, state_nx;
    logic [3:0]        idx;
    logic              snap_mode;
    logic [TIME_W-1:0] snap_time;
    logic [7:0]        conv    [8];
    logic [7:0]        digit_q [8];
    logic [7:0]        line_byte;
    logic              last_byte;

    bin2ascii_2digit u_hour (
        .bin  ({2'b00, snap_time[HOUR_MSB:HOUR_LSB]}),
        .tens (conv[0]),
        .ones (conv[1])
    );

    bin2ascii_2digit u_min (
        .bin  ({1'b0, snap_time[MIN_MSB:MIN_LSB]}),
        .tens (conv[2]),
        .ones (conv[3])
    );

    bin2ascii_2digit u_sec (
        .bin  ({1'b0, snap_time[SEC_MSB:SEC_LSB]}),
        .tens (conv[4]),
        .ones (conv[5])
    );

    bin2ascii_2digit u_csec (
        .bin  (snap_time[CSEC_MSB:CSEC_LSB]),
        .tens (conv[6]),
        .ones (conv[7])
    );

    assign last_byte = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            snap_mode <= 1'b0;
            snap_time <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.i_report) begin
                snap_mode <= bus.i_mode;
                snap_time <= bus.i_time;
            end
            if (state == LOAD) begin
                for (int i = 0; i < 8; i++) digit_q[i] <= conv[i];
            end
            if (state == IDLE) begin
                idx <= 4'd0;
            end else if (state == WAIT_DONE && !bus.i_tx_busy) begin
                idx <= last_byte ? 4'd0 : idx + 4'd1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        bus.o_tx_start = 1'b0;
        case (state)
            IDLE:      if (bus.i_report) state_nx = LOAD;
            LOAD:      state_nx = SEND;
            SEND: begin
                if (!bus.i_tx_busy) begin
                    bus.o_tx_start = 1'b1;
                    state_nx       = WAIT_ACK;
                end
            end
            WAIT_ACK:  if (bus.i_tx_busy) state_nx = WAIT_DONE;
            WAIT_DONE: if (!bus.i_tx_busy) state_nx = last_byte ? IDLE : SEND;
            default:   state_nx = IDLE;
        endcase
    end

    // Byte selection depends only on idx and registered digits, so the
    // presented byte cannot change between the strobe and WAIT_DONE exit.
    always_comb begin
        line_byte = 8'h00;
        case (idx)
            4'd0:    line_byte = snap_mode ? ASCII_S : ASCII_W;
            4'd1:    line_byte = ASCII_SPACE;
            4'd2:    line_byte = digit_q[0];
            4'd3:    line_byte = digit_q[1];
            4'd4:    line_byte = ASCII_COLON;
            4'd5:    line_byte = digit_q[2];
            4'd6:    line_byte = digit_q[3];
            4'd7:    line_byte = ASCII_COLON;
            4'd8:    line_byte = digit_q[4];
            4'd9:    line_byte = digit_q[5];
            4'd10:   line_byte = ASCII_DOT;
            4'd11:   line_byte = digit_q[6];
            4'd12:   line_byte = digit_q[7];
            4'd13:   line_byte = (P_EOL_CRLF != 0) ? ASCII_CR : ASCII_LF;
            4'd14:   line_byte = ASCII_LF;
            default: line_byte = 8'h00;
        endcase
    end

    always_comb begin
        bus.o_busy    = (state != IDLE);
        bus.o_tx_data = 8'h00;
        if (state == SEND || state == WAIT_ACK || state == WAIT_DONE) begin
            bus.o_tx_data = line_byte;
        end
    end

endmodule

// File: doc/time_ascii_reporter.md
TIME_ASCII_REPORTER -- requirements
Module: time_ascii_reporter

Interface
REQ-001 SHALL have parameter P_EOL_CRLF, default 1, meaning 1 = line ends with CR LF and 0 = line ends with LF only.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_report  input  1  single-cycle pulse requesting one report line.
REQ-005 SHALL have port i_mode  input  1  0 = watch, 1 = stopwatch; selects the prefix character.
REQ-006 SHALL have port i_time  input  24  time in binary, packed as {hour[23:19], min[18:13], sec[12:7], msec[6:0]} (msec in centiseconds).
REQ-007 SHALL have port i_tx_busy  input  1  UART transmitter busy; high for the whole byte frame.
REQ-008 SHALL have port o_tx_data  output  8  ASCII byte presented to the transmitter.
REQ-009 SHALL have port o_tx_start  output  1  single-cycle strobe; o_tx_data is valid in that cycle.
REQ-010 SHALL have port o_busy  output  1  high from request acceptance until the last byte completes.

Function
REQ-011 SHALL send the line "M HH:MM:SS.CC" followed by EOL.
  - M is 'W' (0x57) for watch or 'S' (0x53) for stopwatch.
  - The line is 15 bytes with CR LF, 14 bytes with LF only.
REQ-012 SHALL accept i_report only in IDLE; in the acceptance cycle it latches i_time and i_mode into a snapshot, and the line reflects only that snapshot.
REQ-013 SHALL ignore i_report while o_busy=1; no queuing.
REQ-014 SHALL convert each field to two decimal ASCII digits ('0'=0x30), leading zero included.
  - Any field value >99 SHALL be sent as "99".
REQ-015 SHALL use FSM states IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE:
  - IDLE -> LOAD on accepted request.
  - LOAD -> SEND after one cycle; conversion is registered.
  - In SEND, it SHALL pulse o_tx_start for exactly one cycle when i_tx_busy=0, then go to WAIT_ACK; if i_tx_busy=1, it SHALL stay in SEND without strobing.
  - WAIT_ACK -> WAIT_DONE when i_tx_busy=1.
  - WAIT_DONE -> SEND (next byte) or IDLE (after the last byte) when i_tx_busy=0.
REQ-016 SHALL hold o_tx_data stable from the o_tx_start cycle until WAIT_DONE exits.
REQ-017 SHALL place the first o_tx_start no earlier than 2 cycles after acceptance.
REQ-018 SHALL use a 4-bit byte index that counts 0..N-1 and resets to 0 on return to IDLE.
REQ-019 SHALL drop o_busy in the cycle after the final WAIT_DONE exit; a new i_report is accepted in that same IDLE cycle.
REQ-020 SHALL keep o_tx_start=0 in every state except SEND.

Reset
REQ-021 SHALL, while rst=0, force:
  - the FSM to IDLE and the byte index to 0;
  - the snapshot to 0;
  - o_tx_data=8'h00, o_tx_start=0, o_busy=0.
REQ-022 SHALL, on reset assertion mid-line, abort the line immediately with no further strobes; after release it sends nothing until a new i_report.

Structure
REQ-023 SHALL place the following in a shared package:
  - ASCII constants: 'W', 'S', ':', '.', ' ', CR, LF, '0';
  - the FSM state encoding;
  - the field bit positions of the 24-bit time bus, shared with the watch/stopwatch path.
REQ-024 SHALL instantiate sub-module bin2ascii_2digit four times (7-bit in -> two ASCII bytes, saturating at 99).

Verification
REQ-025 SHALL cover a watch line:
  - Stimulus: i_mode=0, time 12:34:56.78, tx model with busy 10 cycles per byte.
  - Response: bytes 57 20 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A, exactly 15 strobes.
REQ-026 SHALL cover a stopwatch line with zero time and P_EOL_CRLF=0:
  - Stimulus: i_mode=1, time 0:00:00.00.
  - Response: "S 00:00:00.00\n", 14 bytes.
REQ-027 SHALL cover saturation:
  - Stimulus: msec=127, hour=31.
  - Response: hour bytes "31", msec bytes "99".
REQ-028 SHALL cover the snapshot and request-ignore rules:
  - Stimulus: change i_time and pulse i_report again during transmission.
  - Response: the line carries the original snapshot, and no second line is sent.
REQ-029 SHALL cover a transmitter that is already busy:
  - Stimulus: i_tx_busy held 1 at request for 20 cycles.
  - Response: no o_tx_start until busy falls, then normal sequence.
REQ-030 SHALL cover reset mid-line:
  - Stimulus: assert rst after byte 5.
  - Response: all outputs 0 immediately, and no strobes until the next i_report.
